// File: rtl/mem_ctr.sv
// mem_ctr: bus-2 main-memory slave serving whole-line reads and writes after MEM_DELAY cycles.
// Line data moves as little-endian DATA_BUS_SIZE beats on the shared tri-state D2.
module mem_ctr #(
  parameter int ADDR2_BUS_SIZE  = 15,
  parameter int DATA_BUS_SIZE   = 16,
  parameter int CTR2_BUS_SIZE   = 2,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int MEM_DELAY       = 100
) (
  input  logic                      CLK,
  input  logic                      RESET,
  inout  wire  [ADDR2_BUS_SIZE-1:0] A2_WIRE,
  inout  wire  [DATA_BUS_SIZE-1:0]  D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2_WIRE,
  input  logic                      M_DUMP
);
  localparam int LINES  = 2 ** ADDR2_BUS_SIZE;
  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int BEATS  = LINE_W / DATA_BUS_SIZE;
  localparam int BW     = $clog2(BEATS);
  localparam int CW     = $clog2(MEM_DELAY + 2);
  localparam int OFF    = $clog2(CACHE_LINE_SIZE);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = 1;
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = 2;
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = 3;

  typedef enum logic [2:0] {IDLE, RECV, WAIT_R, WAIT_W, SEND, ACK} state_t;

  state_t                    st, nxt;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             beat;
  logic [ADDR2_BUS_SIZE-1:0] addr;
  logic [LINE_W-1:0]         line, init_line, rd_line;
  logic [LINE_W-1:0]         mem [LINES];
  // Lines never written read back their power-on pattern byte[a] = a[7:0].
  logic [LINES-1:0]          written = '0;
  logic                      is_rd, is_wr, done, drive_c2, drive_d2;
  logic                      unused_dump;

  assign unused_dump = M_DUMP;
  assign is_rd       = C2_WIRE == C2_READ_LINE;
  assign is_wr       = C2_WIRE == C2_WRITE_LINE;
  assign done        = cnt == CW'(MEM_DELAY);
  assign rd_line     = written[addr] ? mem[addr] : init_line;

  always_comb begin
    init_line = '0;
    for (int i = 0; i < CACHE_LINE_SIZE; i++) init_line[8*i +: 8] = 8'({addr, OFF'(i)});
  end

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) st <= IDLE;
    else st <= nxt;

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (is_rd) nxt = WAIT_R; else if (is_wr) nxt = RECV;
      RECV:    if (beat == BW'(BEATS - 1)) nxt = WAIT_W;
      WAIT_R:  if (done) nxt = SEND;
      WAIT_W:  if (done) nxt = ACK;
      SEND:    if (beat == BW'(BEATS - 1)) nxt = IDLE;
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    drive_c2 = st == SEND || st == ACK;
    drive_d2 = st == SEND;
  end

  assign C2_WIRE = drive_c2 ? C2_RESPONSE : 'z;
  assign D2_WIRE = drive_d2 ? line[beat*DATA_BUS_SIZE +: DATA_BUS_SIZE] : 'z;

  // The beat index wraps to zero after the last beat of both RECV and SEND.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      cnt  <= '0;
      beat <= '0;
      addr <= '0;
      line <= '0;
    end else begin
      if (st == IDLE && (is_rd || is_wr)) begin
        addr <= A2_WIRE;
        cnt  <= CW'(1);
      end else if (st == RECV || st == WAIT_R || st == WAIT_W) cnt <= cnt + 1'b1;
      if (st == IDLE && is_wr && !is_rd) begin
        line[DATA_BUS_SIZE-1:0] <= D2_WIRE;
        beat                    <= BW'(1);
      end else if (st == RECV) begin
        line[beat*DATA_BUS_SIZE +: DATA_BUS_SIZE] <= D2_WIRE;
        beat                                      <= beat + 1'b1;
      end else if (st == SEND) beat <= beat + 1'b1;
      if (st == WAIT_R && done) line <= rd_line;
    end

  always_ff @(posedge CLK)
    if (st == WAIT_W && done) begin
      mem[addr]     <= line;
      written[addr] <= 1'b1;
    end
endmodule

// File: doc/mem_ctr.md
Name: mem_ctr

Overview:
- Main-memory controller; the slave on bus 2, directly downstream of the cache.
- Serves whole-line C2_READ_LINE and C2_WRITE_LINE transactions after a fixed MEM_DELAY latency.
- Line data moves as 16-bit little-endian beats on the shared tri-state D2.
- Backing store is a byte array of 2^(ADDR2_BUS_SIZE) lines × CACHE_LINE_SIZE bytes.

Parameters:
- ADDR2_BUS_SIZE, 15, line-address width (tag+set); byte address = {A2, OFFSET zeros}.
- DATA_BUS_SIZE, 16, D2 width; one beat = 2 bytes.
- CTR2_BUS_SIZE, 2, C2 width. Encodings: C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3.
- CACHE_LINE_SIZE, 16, bytes per line; BEATS = CACHE_LINE_SIZE/2 = 8.
- MEM_DELAY, 100, cycles from command edge to response; must be ≥ BEATS.

Ports:
- CLK  input  1  clock; all sampling on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- A2_WIRE  inout  ADDR2_BUS_SIZE  line address; master-driven, never driven by this block.
- D2_WIRE  inout  DATA_BUS_SIZE  data beats; [7:0]=lower byte, [15:8]=next byte.
- C2_WIRE  inout  CTR2_BUS_SIZE  command/response.
- M_DUMP  input  1  rising edge prints every non-zero line (address, bytes in binary); simulation only.

Behaviour:
- Reset (RESET=0, async): FSM→IDLE, counters→0, D2/C2 drivers→Z immediately, including mid-transaction. The memory array is NOT cleared. Init at time 0 only: byte[a] = a[7:0].
- Bus ownership: master drives C2 for the command cycle, then releases it. This block drives C2/D2 only in SEND and ACK and is Z otherwise. Drives change just after a rising edge; the master samples at the next rising edge.
- States: IDLE, RECV, WAIT_R, WAIT_W, SEND, ACK.
- IDLE:
  - Sample at each edge. C2_READ_LINE → latch A2, go WAIT_R, cnt=1.
  - C2_WRITE_LINE → latch A2, store beat 0 from D2 into bytes 0/1, go RECV, beat=1, cnt=1.
  - C2_NOP, C2_RESPONSE, Z or X → ignored.
- RECV: beat k (k=1..7) captured at command edge E0+k into bytes 2k/2k+1. cnt increments every edge. After beat 7 → WAIT_W. Commands seen on C2 while busy are ignored.
- WAIT_R / WAIT_W: cnt increments per edge. At edge E0+MEM_DELAY go to SEND or ACK respectively.
- SEND:
  - Drive C2=C2_RESPONSE with beat 0. The master samples C2_RESPONSE and beat 0 at E0+MEM_DELAY+1.
  - Beats 1..7 are sampled at the following 7 edges. C2_RESPONSE is held throughout.
  - After the edge that samples beat 7: release C2/D2 to Z, go IDLE.
- ACK: drive C2=C2_RESPONSE (D2 Z) for exactly one cycle, sampled at E0+MEM_DELAY+1, then release and go IDLE.
- Write data is committed to the array at entry to ACK. A read of the same line issued afterwards returns the new data.
- Earliest next command: sampled at the edge following release (one idle cycle between transactions).
- Address wrap: none needed; A2 covers the array exactly.
- Counter: ceil(log2(MEM_DELAY+2)) bits, no overflow within a transaction.
- Reset during RECV/WAIT_W: the partial write is discarded and the array is unchanged.

Test Plan:
- Read, init data: READ_LINE A2=0x0003 at edge E0 → C2=RESPONSE sampled at E0+101. Beats 0x3130, 0x3332, …, 0x3F3E on 8 consecutive edges, then C2/D2 Z.
- Write then read: WRITE_LINE A2=0x0010, beats 0x0100,0x0302,…,0x0F0E → RESPONSE at E0+101 for one cycle. A following READ_LINE of 0x0010 returns the identical 8 beats.
- Command while busy: WRITE_LINE asserted again at E0+20 during WAIT_R of a read → ignored. Read completes unchanged and the line is not modified.
- Reset mid-SEND: RESET=0 after beat 3 → C2/D2 Z within the same timestep, FSM IDLE. A subsequent READ_LINE of the same line returns full correct data.
- Reset mid-RECV: RESET=0 after beat 4 of a write to 0x0020 → a later read returns init pattern 0x0100…0x0F0E for that line.
- MEM_DELAY=8 corner: write completes RECV exactly as WAIT_W expires → RESPONSE sampled at E0+9, no beat lost.
